// File: rtl/crossbar_out_port_if.sv
// crossbar_out_port_if
//   Bundles the channel-side, grant-side and egress-side signals of one
//   crossbar output port.
//   slave  : the output port itself (consumes channels/grant, drives egress)
//   master : the surrounding fabric (drives channels/grant, consumes egress)
//   Channel i of in_data occupies bits [i*DATA_W +: DATA_W].
interface crossbar_out_port_if #(
    parameter int NUM_IN = 4,
    parameter int DATA_W = 32,
    parameter int SEL_W  = $clog2(NUM_IN),
    parameter int CNT_W  = 16
);
    logic [NUM_IN-1:0]        in_valid;
    logic [NUM_IN*DATA_W-1:0] in_data;
    logic [NUM_IN-1:0]        in_last;
    logic [NUM_IN-1:0]        in_ready;
    logic [SEL_W-1:0]         sel;
    logic                     sel_valid;
    logic                     sel_ready;
    logic                     out_valid;
    logic [DATA_W-1:0]        out_data;
    logic                     out_last;
    logic                     out_ready;
    logic                     busy;
    logic                     sel_err;
    logic [CNT_W-1:0]         pkt_cnt;

    modport slave (
        input  in_valid, in_data, in_last, sel, sel_valid, out_ready,
        output in_ready, sel_ready, out_valid, out_data, out_last,
               busy, sel_err, pkt_cnt
    );

    modport master (
        output in_valid, in_data, in_last, sel, sel_valid, out_ready,
        input  in_ready, sel_ready, out_valid, out_data, out_last,
               busy, sel_err, pkt_cnt
    );
endinterface

// File: rtl/crossbar_out_port.sv
// crossbar_out_port
//   One egress port of the switch fabric. A grant (sel/sel_valid) locks the
//   port onto one input channel until that channel's last beat is accepted.
//   Accepted beats go through a 2-entry FIFO so the egress side is driven
//   from registers and keeps full rate under backpressure.
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous, active-low
//   bus   - crossbar_out_port_if.slave: channel inputs, grant handshake,
//           egress handshake, busy, sel_err pulse, wrapping packet counter
module crossbar_out_port #(
    parameter int NUM_IN = 4,
    parameter int DATA_W = 32,
    parameter int SEL_W  = $clog2(NUM_IN),
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               reset,
    crossbar_out_port_if.slave bus
);
    typedef enum logic {IDLE, XFER} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [SEL_W-1:0]    r_gsel;
    logic [1:0]          r_count;
    logic [DATA_W-1:0]   r_head_data;
    logic                r_head_last;
    logic [DATA_W-1:0]   r_tail_data;
    logic                r_tail_last;
    logic                r_sel_err;
    logic [CNT_W-1:0]    r_pkt_cnt;

    logic                w_sel_ok;
    logic                w_grant;
    logic                w_bad_grant;
    logic [NUM_IN-1:0]   w_in_ready;
    logic                w_ch_valid;
    logic [DATA_W-1:0]   w_ch_data;
    logic                w_ch_last;
    logic                w_push;
    logic                w_pop;
    logic                w_sel_ready;

    assign w_sel_ok    = int'(bus.sel) < NUM_IN;
    assign w_grant     = (r_state == IDLE) && bus.sel_valid && w_sel_ok;
    assign w_bad_grant = (r_state == IDLE) && bus.sel_valid && !w_sel_ok;

    // Channel mux and ready decode. Ready uses only registered state, so
    // there is no combinational path from out_ready back to in_ready.
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_ch_valid = 1'b0;
        w_ch_data  = '0;
        w_ch_last  = 1'b0;
        w_in_ready = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (int'(r_gsel) == i) begin
                w_ch_valid    = bus.in_valid[i];
                w_ch_data     = bus.in_data[i*DATA_W +: DATA_W];
                w_ch_last     = bus.in_last[i];
                w_in_ready[i] = (r_state == XFER) && (r_count != 2'd2);
            end
        end
    end

    // Only the granted bit of w_in_ready can be set.
    assign w_push = w_ch_valid && (|w_in_ready);
    assign w_pop  = (r_count != 2'd0) && bus.out_ready;

    always_comb begin
        w_state_next = r_state;
        w_sel_ready  = 1'b0;
        case (r_state)
            IDLE: begin
                w_sel_ready = 1'b1;
                if (w_grant) w_state_next = XFER;
            end
            XFER: begin
                if (w_push && w_ch_last) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_gsel    <= '0;
            r_sel_err <= 1'b0;
            r_pkt_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_sel_err <= w_bad_grant;
            if (w_grant) r_gsel <= bus.sel;
            if (w_pop && r_head_last) r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
        end
    end

    // FIFO head: the entry presented on the egress port.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count     <= 2'd0;
            r_head_data <= '0;
            r_head_last <= 1'b0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head_data <= w_ch_data;
                        r_head_last <= w_ch_last;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    if (r_count == 2'd2) begin
                        r_head_data <= r_tail_data;
                        r_head_last <= r_tail_last;
                    end
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    // Push while full is impossible, so count is 1 here:
                    // the new beat replaces the departing head directly.
                    r_head_data <= w_ch_data;
                    r_head_last <= w_ch_last;
                end
                default: ;
            endcase
        end
    end

    // FIFO second entry, written only when a push lands behind a held head.
    // NOTE: this storage is not reset; it is never observed until r_count
    // says it holds a beat, and skipping reset keeps it plain flops.
    always_ff @(posedge clk) begin
        if (w_push && !w_pop && (r_count == 2'd1)) begin
            r_tail_data <= w_ch_data;
            r_tail_last <= w_ch_last;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.sel_ready = w_sel_ready;
    assign bus.out_valid = (r_count != 2'd0);
    assign bus.out_data  = r_head_data;
    assign bus.out_last  = r_head_last;
    assign bus.busy      = (r_state == XFER) || (r_count != 2'd0);
    assign bus.sel_err   = r_sel_err;
    assign bus.pkt_cnt   = r_pkt_cnt;
endmodule

// File: doc/crossbar_out_port.md
# crossbar_out_port

Parametrised crossbar output port for the switch fabric: selects one of NUM_IN input channels by a registered grant and forwards its packet beats to one output over a valid/ready handshake. A 2-entry output FIFO gives registered outputs and full throughput under backpressure. The grant locks for a whole packet (until the `last` beat) and then releases. The block sits after the arbiter and drives one egress port; one instance per output.

## Interface

Parameters:

- NUM_IN, 4, number of input channels (≥2)
- DATA_W, 32, beat data width
- SEL_W, $clog2(NUM_IN), grant index width
- CNT_W, 16, packet counter width

Ports:

- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low
- in_valid  in  NUM_IN  per-channel beat valid
- in_data  in  NUM_IN*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]
- in_last  in  NUM_IN  per-channel end-of-packet flag
- in_ready  out  NUM_IN  per-channel ready, one-hot or zero
- sel  in  SEL_W  requested channel index
- sel_valid  in  1  grant request
- sel_ready  out  1  grant accepted when sel_valid & sel_ready
- out_valid  out  1  output beat valid
- out_data  out  DATA_W  output beat
- out_last  out  1  output end-of-packet
- out_ready  in  1  downstream ready
- busy  out  1  grant locked or FIFO non-empty
- sel_err  out  1  one-cycle pulse on an out-of-range grant
- pkt_cnt  out  CNT_W  count of packets completed at the output; wraps

## Operation

- States: IDLE, XFER. Grant register `gsel`. FIFO holds 2 entries of {last, data}, with a `count` of 0..2.
- IDLE:
  - sel_ready = 1.
  - On sel_valid with sel < NUM_IN: gsel <= sel, go to XFER.
  - On sel_valid with sel ≥ NUM_IN: the request is consumed, sel_err pulses for 1 cycle, and the state stays IDLE.
- XFER:
  - sel_ready = 0.
  - in_ready[gsel] = (count < 2). All other in_ready bits are 0.
  - A beat is accepted when in_valid[gsel] & in_ready[gsel]. The accepted beat is pushed into the FIFO.
  - If the accepted beat has in_last=1, go to IDLE on the next cycle.
- In IDLE, all in_ready bits are 0.
- A new grant may be accepted while the FIFO is still draining. FIFO order preserves packet order.
- Output side:
  - out_valid = (count > 0). out_data and out_last come from the FIFO head, driven by registers.
  - A pop happens on out_valid & out_ready.
  - Simultaneous push and pop: count is unchanged and the order is preserved.
  - Push when full cannot occur, because in_ready is 0.
- pkt_cnt increments by 1 on each pop with out_last=1 and wraps from 2^CNT_W−1 to 0.
- busy = (state == XFER) | (count != 0).
- Non-selected channels are ignored regardless of their valid, data or last.

## Timing

- Reset (reset == 0 at a clk edge) sets: state IDLE, count 0, out_valid 0, out_data 0, out_last 0, sel_err 0, pkt_cnt 0, gsel 0, in_ready all 0, busy 0. sel_ready is 1 from the first cycle after reset.
- Reset mid-packet drops the FIFO contents and releases the grant immediately. There is no partial flush.
- Grant latency: sel accepted at edge N; in_ready[sel] can be asserted in cycle N+1.
- Data latency: a beat accepted at edge N appears on out_data/out_valid in cycle N+1 (1-cycle latency).
- Throughput: 1 beat/cycle with out_ready held high. count stays at 1.
- Backpressure: with out_ready=0, 2 beats are absorbed, then in_ready drops. in_ready depends only on registered state; there is no combinational path from out_ready to in_ready.
- Single-beat packet (last on the first beat): XFER lasts 1 cycle; IDLE is re-entered at the next edge.
- Timing paths:
  - sel_ready depends combinationally only on state.
  - in_ready depends only on state, gsel and count.
  - out_* are registered.

## Test plan

- Reset: drive reset=0 for 2 cycles with random inputs → out_valid=0, out_data=0, in_ready=0, pkt_cnt=0, sel_ready=1.
- Basic route, with NUM_IN=4:
  - Stimulus: grant sel=2; channel 2 sends 4 beats 0xA0..0xA3, last on 0xA3; out_ready=1.
  - Required: out_data = A0, A1, A2, A3 on consecutive cycles, each 1 cycle after acceptance; out_last only on A3.
  - Required: pkt_cnt=1; channels 0, 1, 3 never see in_ready.
- Backpressure:
  - Stimulus: same packet with out_ready=0 for 5 cycles, then 1.
  - Required: exactly 2 beats accepted, then in_ready[2]=0; after release, all 4 beats arrive in order with no loss or duplication.
- Back-to-back grants:
  - Stimulus: packet on ch1 (2 beats), then sel=3 offered in the cycle after the last beat is accepted, while the FIFO is still non-empty.
  - Required: grant accepted; ch3 beats follow ch1's beats in order; pkt_cnt=2; busy stays 1 throughout.
- Out-of-range grant:
  - Stimulus: sel=5 with SEL_W=3, NUM_IN=4.
  - Required: sel_err high for 1 cycle; state stays IDLE; no in_ready asserted; a following sel=0 is accepted normally.
- Reset mid-packet and counter wrap:
  - Stimulus: assert reset after 2 of 4 beats.
  - Required: out_valid=0 next cycle; sel_ready=1.
  - Stimulus: with CNT_W=2, send 5 single-beat packets.
  - Required: pkt_cnt sequence 1, 2, 3, 0, 1.
